// File: rtl/laser_link_pkg.sv
// Shared laser link definitions: rx FSM states, frame width, defaults.
// Imported by the laser transmitter and receiver.
package laser_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int   FRAME_DATA_BITS  = 8;
  localparam int   DEF_CLKS_PER_BIT = 4;
  localparam logic DEF_IDLE_LEVEL   = 1'b0;

endpackage

// File: rtl/laser_rx_sampler.sv
// Synchronizer + 3-deep history + 2-of-3 majority on the photodiode bit.
// Ports: clock, reset_n, laser_in (async) -> s (synced), maj (vote of window).
import laser_link_pkg::*;

module laser_rx_sampler #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = DEF_IDLE_LEVEL
) (
  input  logic clock,
  input  logic reset_n,
  input  logic laser_in,
  output logic s,
  output logic maj
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             win;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      win    <= {3{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], laser_in};
      win    <= {win[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign s   = sync_q[SYNC_STAGES-1];
  assign maj = (win[0] & win[1]) |
               (win[0] & win[2]) |
               (win[1] & win[2]);

endmodule

// File: rtl/laser_byte_receiver.sv
// Laser link deframer: start detect, mid-bit majority sampling, byte out.
// Ports: clock, reset_n, en, laser_in -> data_valid/data_out, frame_err, busy, counters.
import laser_link_pkg::*;

module laser_byte_receiver #(
  parameter int   CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int   SYNC_STAGES  = 2,
  parameter logic IDLE_LEVEL   = DEF_IDLE_LEVEL
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       laser_in,
  output logic                       data_valid,
  output logic [FRAME_DATA_BITS-1:0] data_out,
  output logic                       frame_err,
  output logic                       busy,
  output logic [15:0]                byte_count,
  output logic [7:0]                 err_count
);

  localparam int   CW   = $clog2(CLKS_PER_BIT);
  localparam int   BW   = $clog2(FRAME_DATA_BITS);
  localparam int   HALF = CLKS_PER_BIT / 2;
  localparam logic ACT  = ~IDLE_LEVEL;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_DEC  = CW'(HALF + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_DATA_BITS - 1);

  logic s;
  logic maj;

  laser_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (IDLE_LEVEL)
  ) u_sampler (
    .clock    (clock),
    .reset_n  (reset_n),
    .laser_in (laser_in),
    .s        (s),
    .maj      (maj)
  );

  rx_state_t                  state;
  logic [CW-1:0]              cyc;
  logic [CW-1:0]              brk_cnt;
  logic [BW-1:0]              bit_idx;
  logic [FRAME_DATA_BITS-1:0] shreg;

  logic at_dec;
  logic at_last;
  logic [CW-1:0] cyc_nxt;

  assign at_dec  = (cyc == CYC_DEC);
  assign at_last = (cyc == CYC_LAST);
  assign cyc_nxt = at_last ? '0 : cyc + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cyc        <= '0;
      brk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      data_out   <= '0;
      byte_count <= '0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        cyc     <= '0;
        bit_idx <= '0;
        brk_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (s == ACT) begin
              state <= START;
              cyc   <= '0;
            end
          end
          START: begin
            cyc <= cyc_nxt;
            if (at_dec && maj != ACT) begin
              state <= IDLE;
            end else if (at_last) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            cyc <= cyc_nxt;
            if (at_dec) begin
              shreg <= {maj, shreg[FRAME_DATA_BITS-1:1]};
            end
            if (at_last) begin
              if (bit_idx == BIT_LAST) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          STOP: begin
            cyc <= cyc_nxt;
            // Leave at the decision point so a back-to-back start is seen.
            if (at_dec) begin
              if (maj == IDLE_LEVEL) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                byte_count <= byte_count + 16'd1;
                state      <= IDLE;
              end else begin
                frame_err <= 1'b1;
                if (err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
                end
                brk_cnt <= '0;
                state   <= BREAK;
              end
            end
          end
          BREAK: begin
            if (s == IDLE_LEVEL) begin
              if (brk_cnt == CYC_LAST) begin
                brk_cnt <= '0;
                state   <= IDLE;
              end else begin
                brk_cnt <= brk_cnt + 1'b1;
              end
            end else begin
              brk_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_laser_byte_receiver.sv
// Directed bench for laser_byte_receiver: table of frames plus corner sequences.
// Default parameters: 4 clocks/bit, 2 sync stages, idle level 0.
module tb_laser_byte_receiver;

  localparam int CPB = 4;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic        laser_in;
  logic        data_valid;
  logic [7:0]  data_out;
  logic        frame_err;
  logic        busy;
  logic [15:0] byte_count;
  logic [7:0]  err_count;

  laser_byte_receiver dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en),
    .laser_in   (laser_in),
    .data_valid (data_valid),
    .data_out   (data_out),
    .frame_err  (frame_err),
    .busy       (busy),
    .byte_count (byte_count),
    .err_count  (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc_n = 0;
  int          dv_cnt = 0;
  int          fe_cnt = 0;
  int          both_cnt = 0;
  int          dv_cyc = 0;
  logic        busy_seen = 1'b0;
  logic [7:0]  dv_q[$];

  always @(posedge clock) cyc_n <= cyc_n + 1;

  always @(negedge clock) begin
    if (data_valid) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc_n;
      dv_q.push_back(data_out);
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (data_valid && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // flip: cycle within the bit whose level is inverted (-1 = none)
  task automatic send_bit(input logic v, input int flip);
    for (int c = 0; c < CPB; c++) begin
      laser_in = (c == flip) ? ~v : v;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bad,
                            input int idle, input int fbit);
    send_bit(1'b1, -1);
    for (int i = 0; i < 8; i++) send_bit(b[i], (i == fbit) ? 2 : -1);
    for (int i = 0; i < bad; i++) send_bit(1'b1, -1);
    laser_in = 1'b0;
    tick(idle);
  endtask

  typedef struct {
    logic [7:0] b;
    int         bad;
    int         idle;
    int         dv;
    int         fe;
  } vec_t;

  vec_t tab[6];

  int         dv0;
  int         fe0;
  int         st;
  int         exp_bc;
  int         exp_ec;
  logic [7:0] exp_data;

  initial begin
    tab[0] = '{8'h00, 0, 12, 1, 0};
    tab[1] = '{8'hFF, 0, 12, 1, 0};
    tab[2] = '{8'h3C, 3, 4,  0, 1};
    tab[3] = '{8'h3C, 0, 12, 1, 0};
    tab[4] = '{8'h01, 0, 12, 1, 0};
    tab[5] = '{8'h80, 0, 12, 1, 0};

    reset_n  = 1'b0;
    en       = 1'b1;
    laser_in = 1'b0;
    tick(3);
    check("rst_data_valid", {31'd0, data_valid}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_data_out", {24'd0, data_out}, 0);
    check("rst_byte_count", {16'd0, byte_count}, 0);
    check("rst_err_count", {24'd0, err_count}, 0);
    reset_n = 1'b1;
    tick(4);

    // 0xA5: latency from driving the start edge to data_valid
    st = cyc_n;
    send_frame(8'hA5, 0, 12, -1);
    check("a5_dv_count", dv_cnt, 1);
    check("a5_latency", dv_cyc - st, 43);
    check("a5_data", {24'd0, data_out}, 32'hA5);
    check("a5_byte_count", {16'd0, byte_count}, 1);
    check("a5_err_count", {24'd0, err_count}, 0);
    exp_bc   = 1;
    exp_ec   = 0;
    exp_data = 8'hA5;

    for (int v = 0; v < 6; v++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(tab[v].b, tab[v].bad, tab[v].idle, -1);
      exp_bc = exp_bc + tab[v].dv;
      exp_ec = exp_ec + tab[v].fe;
      if (tab[v].dv != 0) exp_data = tab[v].b;
      check($sformatf("vec%0d_dv", v), dv_cnt - dv0, tab[v].dv);
      check($sformatf("vec%0d_fe", v), fe_cnt - fe0, tab[v].fe);
      check($sformatf("vec%0d_data", v), {24'd0, data_out}, {24'd0, exp_data});
      check($sformatf("vec%0d_bc", v), {16'd0, byte_count}, exp_bc);
      check($sformatf("vec%0d_ec", v), {24'd0, err_count}, exp_ec);
    end

    // back-to-back 0x00, 0xFF: start bit right after the stop bit
    dv_q.delete();
    dv0 = dv_cnt;
    send_frame(8'h00, 0, 4, -1);
    send_frame(8'hFF, 0, 12, -1);
    exp_bc = exp_bc + 2;
    check("b2b_dv", dv_cnt - dv0, 2);
    check("b2b_first", (dv_q.size() > 0) ? {24'd0, dv_q[0]} : 32'hDEAD, 32'h00);
    check("b2b_second", (dv_q.size() > 1) ? {24'd0, dv_q[1]} : 32'hDEAD, 32'hFF);
    check("b2b_bc", {16'd0, byte_count}, exp_bc);

    // single-cycle glitch on idle line
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    busy_seen = 1'b0;
    laser_in = 1'b1;
    tick(1);
    laser_in = 1'b0;
    tick(20);
    check("glitch_busy_seen", {31'd0, busy_seen}, 1);
    check("glitch_busy_end", {31'd0, busy}, 0);
    check("glitch_dv", dv_cnt - dv0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);

    // one corrupted mid-bit sample in bit 3 of 0x5A
    dv0 = dv_cnt;
    send_frame(8'h5A, 0, 12, 3);
    exp_bc = exp_bc + 1;
    check("corrupt_dv", dv_cnt - dv0, 1);
    check("corrupt_data", {24'd0, data_out}, 32'h5A);
    check("corrupt_bc", {16'd0, byte_count}, exp_bc);

    // en dropped during bit 4 of 0x81
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_bit(1'b1, -1);
    for (int i = 0; i < 4; i++) send_bit(1'((8'h81 >> i) & 8'h01), -1);
    en = 1'b0;
    for (int i = 4; i < 8; i++) send_bit(1'((8'h81 >> i) & 8'h01), -1);
    send_bit(1'b0, -1);
    tick(12);
    en = 1'b1;
    tick(4);
    check("en_dv", dv_cnt - dv0, 0);
    check("en_fe", fe_cnt - fe0, 0);
    check("en_bc", {16'd0, byte_count}, exp_bc);
    check("en_ec", {24'd0, err_count}, exp_ec);
    check("en_data_hold", {24'd0, data_out}, 32'h5A);
    send_frame(8'h81, 0, 12, -1);
    exp_bc = exp_bc + 1;
    check("en_after_dv", dv_cnt - dv0, 1);
    check("en_after_data", {24'd0, data_out}, 32'h81);
    check("en_after_bc", {16'd0, byte_count}, exp_bc);

    // asynchronous reset mid-frame
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    #3;
    reset_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_data_out", {24'd0, data_out}, 0);
    check("mrst_bc", {16'd0, byte_count}, 0);
    check("mrst_ec", {24'd0, err_count}, 0);
    check("mrst_dv", {31'd0, data_valid}, 0);
    laser_in = 1'b0;
    tick(3);
    #2;
    reset_n = 1'b1;
    tick(6);
    dv0 = dv_cnt;
    send_frame(8'h7E, 0, 12, -1);
    check("mrst_after_dv", dv_cnt - dv0, 1);
    check("mrst_after_data", {24'd0, data_out}, 32'h7E);
    check("mrst_after_bc", {16'd0, byte_count}, 1);

    // 256 bad stop bits saturate err_count
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 256; i++) send_frame(8'(i), 1, 8, -1);
    check("sat_fe", fe_cnt - fe0, 256);
    check("sat_ec", {24'd0, err_count}, 255);
    check("sat_dv", dv_cnt - dv0, 0);
    check("sat_bc", {16'd0, byte_count}, 1);
    check("sat_data", {24'd0, data_out}, 32'h7E);

    check("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_byte_receiver.md
Name: laser_byte_receiver

Overview:
- Receive-side deframer for the free-space laser link, run at the base clock.
- Synchronizes the raw photodiode input, finds the start bit, takes a 3-sample majority vote at the middle of each bit, and shifts out one byte per frame.
- Feeds the FTDI write queue (data_valid/data_out) and status counters.
- Its framing is exactly what the laser transmitter emits with a bit period of CLKS_PER_BIT base clocks.

Parameters:
- CLKS_PER_BIT, 4: base-clock cycles per laser bit. Legal values are ≥4.
- SYNC_STAGES, 2: number of synchronizer flops on laser_in. Legal values are ≥2.
- IDLE_LEVEL, 1'b0: line level when idle (laser off). The start bit is ~IDLE_LEVEL; the stop bit is IDLE_LEVEL.

Ports:
- clock  in  1  base clock; the single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  receiver enable.
- laser_in  in  1  raw, asynchronous photodiode bit.
- data_valid  out  1  one-cycle strobe; data_out is valid in the same cycle.
- data_out  out  8  last correctly framed byte.
- frame_err  out  1  one-cycle strobe when a stop bit is bad.
- busy  out  1  high in any state other than IDLE.
- byte_count  out  16  count of good bytes; wraps at 65535→0.
- err_count  out  8  count of framing errors; saturates at 255.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low (reset_n).
- Reset values:
  - All outputs are 0.
  - Synchronizer flops and majority window load IDLE_LEVEL.
  - FSM is in IDLE; bit counter and shift register are 0.
- Synchronizer and majority:
  - s is laser_in after SYNC_STAGES flops.
  - win is a 3-entry history of s.
  - maj is the 2-of-3 majority of win.
- Sampling:
  - HALF = CLKS_PER_BIT/2, integer division.
  - cyc counts 0..CLKS_PER_BIT-1 within the current bit.
  - The decision point is cyc == HALF+1, so the window covers cycles HALF-1..HALF+1 of the bit.
- IDLE:
  - When s == ~IDLE_LEVEL: go to START with cyc=0. That cycle is T0.
- START:
  - At the decision point, if maj != ~IDLE_LEVEL the start was a glitch: return to IDLE on the next cycle, with no strobe.
  - Otherwise, when cyc wraps, go to DATA with bit index 0.
- DATA:
  - At the decision point, shift maj into the shift register LSB-first (shift right, insert at bit 7).
  - When cyc wraps after bit index 7, go to STOP. Otherwise increment the bit index.
- STOP, at the decision point:
  - If maj == IDLE_LEVEL: on the next cycle data_out ← shift register, data_valid=1 for one cycle, and byte_count increments. The FSM goes directly to IDLE without waiting for the end of the stop bit, so a back-to-back start bit is detected.
  - Otherwise: frame_err=1 for one cycle on the next cycle, err_count saturating-increments, data_out is unchanged, and the FSM goes to BREAK.
- BREAK:
  - Counts consecutive cycles with s == IDLE_LEVEL; any active sample resets the count.
  - After CLKS_PER_BIT consecutive idle cycles, go to IDLE.
- Latency with default parameters: data_valid is asserted at T0+40. T0 is SYNC_STAGES cycles after the laser_in edge is first sampled.
- Enable:
  - en=0 forces the FSM to IDLE synchronously; any partial byte is discarded.
  - No strobes occur while en=0. Counters and data_out hold their values.
  - The synchronizer keeps running while en=0.
- Reset mid-frame: returns immediately to reset values.
- data_valid and frame_err are never high in the same cycle.

Decomposition:
- laser_link_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
  - FRAME_DATA_BITS=8;
  - default IDLE_LEVEL and CLKS_PER_BIT.
- The package is shared with the laser transmitter.
- Sub-module laser_rx_sampler contains the SYNC_STAGES synchronizer, the 3-deep window and the maj output. It is reused by future multi-lane receivers.

Test Plan:
- Frame 0xA5 with default parameters, ideal edges: exactly one data_valid at T0+40, data_out=0xA5, byte_count=1, err_count=0.
- Frames 0x00 then 0xFF back-to-back, next start bit immediately after the stop bit: two data_valid strobes, values 0x00 then 0xFF, byte_count=2.
- Single-cycle active glitch on an idle line: busy pulses, no data_valid and no frame_err, FSM back in IDLE. Repeat with one corrupted sample at the middle of a data bit of 0x5A: the byte is still received as 0x5A.
- Frame 0x3C with the stop bit held active for 3 bit periods: one frame_err, no data_valid, err_count=1, data_out unchanged. After the line is idle for 4 cycles, frame 0x3C decodes correctly.
- en dropped during bit 4 of 0x81, then raised again: no strobe, counters unchanged. The next full frame, 0x81, is received.
- reset_n asserted mid-frame: all outputs go to 0 asynchronously. After release, 0x7E is received correctly. Separately, 256 bad stop bits leave err_count=255.
